// File: rtl/inst_ram_loader_if.sv
// Word-stream interface between an instruction source and inst_ram_loader.
//   word_in     32-bit instruction word
//   word_valid  word_in is valid this cycle
//   last        word_in is the final word of the load session
//   word_ready  loader can take a word this cycle
// master: instruction source; slave: the loader.
interface inst_ram_loader_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        last;
  logic        word_ready;

  modport master (
    output word_in,
    output word_valid,
    output last,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  last,
    output word_ready
  );
endinterface

// File: rtl/inst_ram_loader.sv
// inst_ram_loader
//   Boot/load path for the byte-wide instruction RAM. Each 32-bit word from the
//   word stream becomes four big-endian byte writes (word[31:24] at the lowest
//   address) on consecutive cycles. One word is taken every 5 cycles.
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        begin a session at base_addr (sampled only in IDLE)
//   base_addr    first byte address, low two bits ignored (word aligned)
//   word_bus     slave side of inst_ram_loader_if (word_in/word_valid/last/word_ready)
//   mem_we/mem_addr/mem_din   RAM byte write port; addr/data hold when idle
//   busy         session active (ACCEPT or WRITE)
//   done         one-cycle pulse at session end
//   overflow     sticky: a word arrived after the top of RAM was passed
//   word_count   words written this session (saturating)
//   checksum     mod-256 sum of written bytes when LOADER_CHECKSUM_EN is
//                defined, otherwise constant 0
module inst_ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  inst_ram_loader_if.slave     word_bus,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_din,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [ADDR_W-1:0]    word_count,
  output logic [7:0]           checksum
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("inst_ram_loader: DEPTH must equal 2**ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0]   PTR_ONE   = 1;
  localparam logic [ADDR_W-1:0] ALIGN_MSK = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     ptr_reg;     // extra MSB marks "past the top of RAM"
  logic [1:0]          idx_reg;
  logic [31:0]         word_reg;
  logic                last_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [7:0]          mem_din_reg;
  logic                overflow_reg;
  logic [ADDR_W-1:0]   word_count_reg;
  logic                full;

  assign full = ptr_reg[ADDR_W];

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCEPT;
      ACCEPT:  if (word_bus.word_valid) begin
                 if (!full)              state_next = WRITE;
                 else if (word_bus.last) state_next = DONE;
               end
      WRITE:   if (idx_reg == 2'd3) state_next = last_reg ? DONE : ACCEPT;
      default: state_next = IDLE;
    endcase
  end

  // Output decode (all taken straight from the state register)
  always_comb begin
    word_bus.word_ready = (state_reg == ACCEPT);
    busy                = (state_reg == ACCEPT) || (state_reg == WRITE);
    done                = (state_reg == DONE);
    mem_we              = (state_reg == WRITE);
  end

  // Datapath. mem_addr/mem_din are loaded one edge ahead so that they are
  // already correct during the first WRITE cycle and hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= '0;
      idx_reg        <= '0;
      word_reg       <= '0;
      last_reg       <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      overflow_reg   <= 1'b0;
      word_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          ptr_reg        <= {1'b0, base_addr & ALIGN_MSK};
          word_count_reg <= '0;
          overflow_reg   <= 1'b0;
        end
        ACCEPT: if (word_bus.word_valid) begin
          if (!full) begin
            word_reg     <= word_bus.word_in;
            last_reg     <= word_bus.last;
            idx_reg      <= 2'd0;
            mem_addr_reg <= ptr_reg[ADDR_W-1:0];
            mem_din_reg  <= word_bus.word_in[31:24];
          end else begin
            overflow_reg <= 1'b1;
          end
        end
        WRITE: begin
          ptr_reg <= ptr_reg + PTR_ONE;
          idx_reg <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            if (word_count_reg != CNT_MAX) word_count_reg <= word_count_reg + 1'b1;
          end else begin
            // Sessions start word aligned, so the carry into the full bit can
            // only happen on the last byte of a word; no wrap check needed here.
            mem_addr_reg <= ptr_reg[ADDR_W-1:0] + PTR_ONE[ADDR_W-1:0];
            mem_din_reg  <= byte_sel(word_reg, idx_reg + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign overflow   = overflow_reg;
  assign word_count = word_count_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg;

  // Accumulates the byte on the bus at the end of each write cycle.
  always_ff @(posedge clk) begin
    if (reset)                            checksum_reg <= '0;
    else if (state_reg == IDLE && start)  checksum_reg <= '0;
    else if (state_reg == WRITE)          checksum_reg <= checksum_reg + mem_din_reg;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [7:0] word_count;
  logic [7:0] checksum;

  int errors = 0;
  int checks = 0;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [7:0] CSUM_T2 = 8'h98;
  localparam logic [7:0] CSUM_T6 = 8'h06;
`else
  localparam logic [7:0] CSUM_T2 = 8'h00;
  localparam logic [7:0] CSUM_T6 = 8'h00;
`endif

  inst_ram_loader_if wb ();

  inst_ram_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_bus   (wb),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: captures every byte write the loader issues
  logic [7:0] ram_model [256];
  logic       written   [256];
  int         write_cnt;
  logic       model_clr;

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 256; i++) written[i] <= 1'b0;
      write_cnt <= 0;
    end else if (mem_we) begin
      ram_model[mem_addr] <= mem_din;
      written[mem_addr]   <= 1'b1;
      write_cnt           <= write_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1);
  end

  // Pulse start at a negedge; returns at the first negedge in ACCEPT.
  task automatic begin_session(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, wb.word_ready, overflow, word_count, checksum} !== {2'b11, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL session_start: busy/ready/ovf/cnt/csum got %b %b %b %h %h, exp 1 1 0 00 00",
               busy, wb.word_ready, overflow, word_count, checksum);
    end
  endtask

  // Offer one word at a negedge in ACCEPT. If exp_write, check the four byte
  // writes and return at the negedge of cycle N+5; otherwise return one cycle
  // after the handshake.
  task automatic send_word(input logic [31:0] w, input logic lst, input logic [7:0] a0,
                           input logic exp_write);
    logic [7:0] eb;
    checks++;
    if (wb.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_word: word_ready got %b exp 1", wb.word_ready);
    end
    wb.word_in = w;
    wb.word_valid = 1'b1;
    wb.last = lst;
    @(negedge clk);
    $display("word %h last=%0d base=%h write=%0d", w, lst, a0, exp_write);
    if (exp_write) begin
      for (int k = 0; k < 4; k++) begin
        eb = w[31-8*k -: 8];
        checks++;
        if ({mem_we, wb.word_ready, mem_addr, mem_din} !== {2'b10, 8'(a0 + k), eb}) begin
          errors++;
          $display("FAIL byte_write[%0d]: we/ready/addr/din got %b %b %h %h, exp 1 0 %h %h",
                   k, mem_we, wb.word_ready, mem_addr, mem_din, 8'(a0 + k), eb);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    base_addr = 8'h40;
    wb.word_in = 32'h0;
    wb.word_valid = 1'b0;
    wb.last = 1'b0;
    model_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_din, busy, done, overflow, word_count, checksum, wb.word_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%h din=%h busy=%b done=%b ovf=%b cnt=%h csum=%h rdy=%b, exp all 0",
               mem_we, mem_addr, mem_din, busy, done, overflow, word_count, checksum, wb.word_ready);
    end
    reset = 1'b0;
    start = 1'b0;
    model_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, wb.word_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stays_idle: busy/ready got %b %b exp 0 0", busy, wb.word_ready);
    end
  endtask

  task automatic test_single_word();
    begin_session(8'h00);
    send_word(32'hE3A01005, 1'b1, 8'h00, 1'b1);
    wb.word_valid = 1'b0;
    wb.last = 1'b0;
    checks++;
    if ({done, busy, mem_we, wb.word_ready, overflow, word_count} !== {5'b10000, 8'd1}) begin
      errors++;
      $display("FAIL single_done: done/busy/we/rdy/ovf/cnt got %b %b %b %b %b %h, exp 1 0 0 0 0 01",
               done, busy, mem_we, wb.word_ready, overflow, word_count);
    end
    checks++;
    if ({mem_addr, mem_din, checksum} !== {8'h03, 8'h05, CSUM_T2}) begin
      errors++;
      $display("FAIL single_hold_csum: addr/din/csum got %h %h %h, exp 03 05 %h",
               mem_addr, mem_din, checksum, CSUM_T2);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done_pulse: done/busy got %b %b exp 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [7:0]  eb;
    words[0] = 32'h0A0B0C0D;
    words[1] = 32'h1A2B3C4D;
    words[2] = 32'hF0E1D2C3;
    begin_session(8'h06);
    for (int i = 0; i < 3; i++)
      send_word(words[i], (i == 2), 8'(8'h04 + 4 * i), 1'b1);
    wb.word_valid = 1'b0;
    wb.last = 1'b0;
    checks++;
    if ({done, word_count} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL stream_done: done/cnt got %b %h exp 1 03", done, word_count);
    end
    for (int i = 0; i < 12; i++) begin
      eb = words[i / 4][31 - 8 * (i % 4) -: 8];
      checks++;
      if ({written[8'h04 + i], ram_model[8'h04 + i]} !== {1'b1, eb}) begin
        errors++;
        $display("FAIL stream_ram[%h]: written/data got %b %h exp 1 %h",
                 8'(8'h04 + i), written[8'h04 + i], ram_model[8'h04 + i], eb);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int cnt_before;
    cnt_before = write_cnt;
    begin_session(8'hFC);
    send_word(32'h11223344, 1'b0, 8'hFC, 1'b1);
    send_word(32'h55667788, 1'b1, 8'h00, 1'b0);
    wb.word_valid = 1'b0;
    wb.last = 1'b0;
    checks++;
    if ({done, overflow, mem_we, word_count} !== {3'b110, 8'd1}) begin
      errors++;
      $display("FAIL overflow_done: done/ovf/we/cnt got %b %b %b %h exp 1 1 0 01",
               done, overflow, mem_we, word_count);
    end
    checks++;
    if (write_cnt - cnt_before !== 4) begin
      errors++;
      $display("FAIL overflow_writes: byte writes got %0d exp 4", write_cnt - cnt_before);
    end
    checks++;
    if ({ram_model[8'hFC], ram_model[8'hFF], ram_model[8'h00]} !== 24'h1144E3) begin
      errors++;
      $display("FAIL overflow_ram: FC/FF/00 got %h %h %h exp 11 44 E3",
               ram_model[8'hFC], ram_model[8'hFF], ram_model[8'h00]);
    end
    @(negedge clk);
    checks++;
    if ({done, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_sticky: done/ovf got %b %b exp 0 1", done, overflow);
    end
  endtask

  task automatic test_reset_mid_write();
    begin_session(8'h10);
    wb.word_in = 32'hAABBCCDD;
    wb.word_valid = 1'b1;
    wb.last = 1'b1;
    @(negedge clk);
    wb.word_valid = 1'b0;
    wb.last = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_din} !== {1'b1, 8'h11, 8'hBB}) begin
      errors++;
      $display("FAIL midreset_idx1: we/addr/din got %b %h %h exp 1 11 BB", mem_we, mem_addr, mem_din);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("word AABBCCDD base=10 interrupted by reset");
    checks++;
    if ({mem_we, busy, wb.word_ready, done, word_count} !== {4'b0000, 8'd0}) begin
      errors++;
      $display("FAIL midreset_idle: we/busy/rdy/done/cnt got %b %b %b %b %h exp 0 0 0 0 00",
               mem_we, busy, wb.word_ready, done, word_count);
    end
    checks++;
    if ({written[8'h10], ram_model[8'h10], written[8'h11], ram_model[8'h11], written[8'h12], written[8'h13]}
        !== {1'b1, 8'hAA, 1'b1, 8'hBB, 2'b00}) begin
      errors++;
      $display("FAIL midreset_ram: 10=%b/%h 11=%b/%h 12w=%b 13w=%b exp 1/AA 1/BB 0 0",
               written[8'h10], ram_model[8'h10], written[8'h11], ram_model[8'h11],
               written[8'h12], written[8'h13]);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, busy} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_stays_idle: we/busy got %b %b exp 0 0", mem_we, busy);
    end
  endtask

  task automatic test_checksum();
    begin_session(8'h20);
    send_word(32'h01020304, 1'b0, 8'h20, 1'b1);
    send_word(32'hFFFFFFFF, 1'b1, 8'h24, 1'b1);
    wb.word_valid = 1'b0;
    wb.last = 1'b0;
    checks++;
    if ({done, word_count, checksum} !== {1'b1, 8'd2, CSUM_T6}) begin
      errors++;
      $display("FAIL checksum_done: done/cnt/csum got %b %h %h exp 1 02 %h",
               done, word_count, checksum, CSUM_T6);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_reset_mid_write();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
